// File: rtl/hazard_fwd_ctl.sv
// Hazard and forwarding controller for an in-order 5-stage MIPS pipeline.
// Tracks in-flight destinations from EX onward; drives stall, bubble, EX hold and forward selects.
module hazard_fwd_ctl #(
  parameter int RW         = 5,
  parameter int DEPTH      = 2,
  parameter int LOAD_STAGE = 2,
  parameter int CW         = 5,
  parameter int FW         = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          iss_valid_i,
  input  logic [RW-1:0] iss_rs_i,
  input  logic [RW-1:0] iss_rt_i,
  input  logic          iss_use_rs_i,
  input  logic          iss_use_rt_i,
  input  logic [RW-1:0] iss_rd_i,
  input  logic          iss_reg_wr_i,
  input  logic          iss_load_i,
  input  logic [CW-1:0] iss_mc_cyc_i,
  input  logic          flush_i,
  output logic          stall_o,
  output logic          bubble_o,
  output logic          ex_hold_o,
  output logic [FW-1:0] fwd_a_o,
  output logic [FW-1:0] fwd_b_o,
  output logic [CW-1:0] mc_cnt_o
);

  // Control state (reset): per-stage valid and multicycle counter.
  logic [DEPTH:0] v_q, v_d;
  logic [CW-1:0]  mc_cnt_q, mc_cnt_d;

  // Payload state (no reset): only meaningful where the matching valid is set.
  logic [DEPTH:0] wr_q, ld_q;
  logic [RW-1:0]  rd_q [DEPTH+1];
  logic [RW-1:0]  rs0_q, rt0_q;
  logic           use_rs0_q, use_rt0_q;

  logic hold, lu, load0;

  function automatic logic hit_f(input logic v, input logic wr,
                                 input logic [RW-1:0] rd, input logic [RW-1:0] r);
    return v & wr & (rd == r) & (r != '0);
  endfunction

  // Load-use: a load too young to forward matches an ISS source.
  always_comb begin
    lu = 1'b0;
    for (int j = 0; j <= DEPTH; j++) begin
      if (j < LOAD_STAGE - 1 && ld_q[j]) begin
        if (iss_use_rs_i && hit_f(v_q[j], wr_q[j], rd_q[j], iss_rs_i)) lu = 1'b1;
        if (iss_use_rt_i && hit_f(v_q[j], wr_q[j], rd_q[j], iss_rt_i)) lu = 1'b1;
      end
    end
  end

  // Descending scan so the youngest matching stage wins.
  always_comb begin
    fwd_a_o = '0;
    fwd_b_o = '0;
    for (int k = DEPTH; k >= 1; k--) begin
      if (v_q[0] && use_rs0_q && hit_f(v_q[k], wr_q[k], rd_q[k], rs0_q)) fwd_a_o = FW'(k);
      if (v_q[0] && use_rt0_q && hit_f(v_q[k], wr_q[k], rd_q[k], rt0_q)) fwd_b_o = FW'(k);
    end
  end

  assign hold      = (mc_cnt_q != '0);
  assign ex_hold_o = hold;
  assign stall_o   = hold | (lu & ~flush_i);
  assign bubble_o  = ~hold & (lu | flush_i);
  assign mc_cnt_o  = mc_cnt_q;
  assign load0     = iss_valid_i & ~bubble_o & ~flush_i;

  always_comb begin
    v_d      = v_q;
    mc_cnt_d = mc_cnt_q;
    if (hold) begin
      v_d[1]   = 1'b0;
      mc_cnt_d = mc_cnt_q - CW'(1);
    end else begin
      v_d[0]   = load0;
      v_d[1]   = v_q[0];
      mc_cnt_d = (load0 && iss_mc_cyc_i != '0) ? iss_mc_cyc_i : '0;
    end
    for (int k = 2; k <= DEPTH; k++) v_d[k] = v_q[k-1];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v_q      <= '0;
      mc_cnt_q <= '0;
    end else begin
      v_q      <= v_d;
      mc_cnt_q <= mc_cnt_d;
    end
  end

  // Stage 1 copies stage 0 even during a hold; its valid is cleared instead.
  always_ff @(posedge clk) begin
    if (!hold) begin
      rd_q[0]   <= iss_rd_i;
      wr_q[0]   <= iss_reg_wr_i;
      ld_q[0]   <= iss_load_i;
      rs0_q     <= iss_rs_i;
      rt0_q     <= iss_rt_i;
      use_rs0_q <= iss_use_rs_i;
      use_rt0_q <= iss_use_rt_i;
    end
    for (int k = 1; k <= DEPTH; k++) begin
      rd_q[k] <= rd_q[k-1];
      wr_q[k] <= wr_q[k-1];
      ld_q[k] <= ld_q[k-1];
    end
  end

endmodule

// File: tb/tb_hazard_fwd_ctl.sv
// Testbench for hazard_fwd_ctl: directed pipeline scenarios plus randomized traffic
// compared against a queue-based model of the in-flight table.
module tb_hazard_fwd_ctl;
  localparam int RW = 5, DEPTH = 2, LOAD_STAGE = 2, CW = 5;
  localparam int FW = $clog2(DEPTH + 1);

  logic clk = 1'b0, reset;
  logic iss_valid_i, iss_use_rs_i, iss_use_rt_i, iss_reg_wr_i, iss_load_i, flush_i;
  logic [RW-1:0] iss_rs_i, iss_rt_i, iss_rd_i;
  logic [CW-1:0] iss_mc_cyc_i;
  logic stall_o, bubble_o, ex_hold_o;
  logic [FW-1:0] fwd_a_o, fwd_b_o;
  logic [CW-1:0] mc_cnt_o;

  int n_checks = 0, n_pass = 0;

  always #5 clk = ~clk;

  hazard_fwd_ctl #(.RW(RW), .DEPTH(DEPTH), .LOAD_STAGE(LOAD_STAGE), .CW(CW), .FW(FW)) dut (
    .clk(clk), .reset(reset), .iss_valid_i(iss_valid_i), .iss_rs_i(iss_rs_i), .iss_rt_i(iss_rt_i),
    .iss_use_rs_i(iss_use_rs_i), .iss_use_rt_i(iss_use_rt_i), .iss_rd_i(iss_rd_i),
    .iss_reg_wr_i(iss_reg_wr_i), .iss_load_i(iss_load_i), .iss_mc_cyc_i(iss_mc_cyc_i),
    .flush_i(flush_i), .stall_o(stall_o), .bubble_o(bubble_o), .ex_hold_o(ex_hold_o),
    .fwd_a_o(fwd_a_o), .fwd_b_o(fwd_b_o), .mc_cnt_o(mc_cnt_o));

  // Reference model: pipe[0] is EX, pipe[k] is k stages later.
  typedef struct {
    bit v; bit [RW-1:0] rd; bit wr; bit ld;
    bit [RW-1:0] rs, rt; bit urs, urt;
  } ent_t;
  ent_t pipe[$];
  int   mcnt;

  function automatic void m_reset();
    ent_t z;
    z.v = 0; z.rd = 0; z.wr = 0; z.ld = 0; z.rs = 0; z.rt = 0; z.urs = 0; z.urt = 0;
    pipe.delete();
    for (int k = 0; k <= DEPTH; k++) pipe.push_back(z);
    mcnt = 0;
  endfunction

  function automatic bit m_hit(int k, logic [RW-1:0] r);
    return pipe[k].v && pipe[k].wr && pipe[k].rd == r && r != 0;
  endfunction

  function automatic bit m_lu();
    for (int j = 0; j < LOAD_STAGE - 1 && j <= DEPTH; j++)
      if (pipe[j].ld && ((iss_use_rs_i && m_hit(j, iss_rs_i)) || (iss_use_rt_i && m_hit(j, iss_rt_i))))
        return 1;
    return 0;
  endfunction

  function automatic bit m_hold();   return mcnt != 0; endfunction
  function automatic bit m_stall();  return m_hold() || (m_lu() && !flush_i); endfunction
  function automatic bit m_bubble(); return !m_hold() && (m_lu() || flush_i); endfunction

  function automatic int m_fwd(bit [RW-1:0] r, bit use_src);
    if (!pipe[0].v || !use_src) return 0;
    for (int k = 1; k <= DEPTH; k++) if (m_hit(k, r)) return k;
    return 0;
  endfunction

  // Advance model and DUT across one rising edge, then settle inputs-update point.
  task automatic tick();
    ent_t e;
    bit h, b;
    h = m_hold();
    b = m_bubble();
    if (h) begin
      e.v = 0; e.rd = 0; e.wr = 0; e.ld = 0; e.rs = 0; e.rt = 0; e.urs = 0; e.urt = 0;
      pipe.insert(1, e);
      void'(pipe.pop_back());
      mcnt = mcnt - 1;
    end else begin
      e.v = iss_valid_i && !b && !flush_i;
      e.rd = iss_rd_i; e.wr = iss_reg_wr_i; e.ld = iss_load_i;
      e.rs = iss_rs_i; e.rt = iss_rt_i; e.urs = iss_use_rs_i; e.urt = iss_use_rt_i;
      pipe.push_front(e);
      void'(pipe.pop_back());
      mcnt = (e.v && iss_mc_cyc_i != 0) ? int'(iss_mc_cyc_i) : 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_iss(bit vld, int rs, int rt, bit urs, bit urt, int rd, bit wr, bit ld, int mc);
    iss_valid_i = vld; iss_rs_i = RW'(rs); iss_rt_i = RW'(rt);
    iss_use_rs_i = urs; iss_use_rt_i = urt; iss_rd_i = RW'(rd);
    iss_reg_wr_i = wr; iss_load_i = ld; iss_mc_cyc_i = CW'(mc);
  endtask

  task automatic drain();
    set_iss(0, 0, 0, 0, 0, 0, 0, 0, 0);
    flush_i = 0;
    repeat (8) begin @(negedge clk); tick(); end
  endtask

  task automatic test_reset();
    m_reset();
    set_iss(0, 0, 0, 0, 0, 0, 0, 0, 0);
    reset = 1; flush_i = 1;
    #2;
    n_checks++; if (stall_o !== 1'b0) $display("FAIL reset_stall: got %b want 0", stall_o); else n_pass++;
    n_checks++; if (bubble_o !== 1'b1) $display("FAIL reset_bubble_flush: got %b want 1", bubble_o); else n_pass++;
    n_checks++; if (ex_hold_o !== 1'b0) $display("FAIL reset_hold: got %b want 0", ex_hold_o); else n_pass++;
    n_checks++; if (fwd_a_o !== '0 || fwd_b_o !== '0) $display("FAIL reset_fwd: got %0d/%0d want 0/0", fwd_a_o, fwd_b_o); else n_pass++;
    n_checks++; if (mc_cnt_o !== '0) $display("FAIL reset_cnt: got %0d want 0", mc_cnt_o); else n_pass++;
    flush_i = 0;
    #1;
    n_checks++; if (bubble_o !== 1'b0) $display("FAIL reset_bubble_noflush: got %b want 0", bubble_o); else n_pass++;
    @(negedge clk);
    reset = 0;
    drain();
  endtask

  task automatic test_forward();
    set_iss(1, 1, 2, 1, 1, 3, 1, 0, 0);        // add r3,r1,r2
    @(negedge clk);
    n_checks++; if (stall_o !== 1'b0) $display("FAIL fwd1_stall_add: got %b want 0", stall_o); else n_pass++;
    tick();
    set_iss(1, 3, 5, 1, 1, 4, 1, 0, 0);        // sub r4,r3,r5
    @(negedge clk);
    n_checks++; if (stall_o !== 1'b0 || bubble_o !== 1'b0) $display("FAIL fwd1_stall_sub: got %b%b want 00", stall_o, bubble_o); else n_pass++;
    tick();
    set_iss(0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    n_checks++; if (fwd_a_o !== 2'd1 || fwd_b_o !== 2'd0) $display("FAIL fwd1_sel: got %0d/%0d want 1/0", fwd_a_o, fwd_b_o); else n_pass++;
    tick();
    drain();
    set_iss(1, 1, 2, 1, 1, 3, 1, 0, 0);        // add r3,r1,r2
    @(negedge clk); tick();
    set_iss(1, 6, 7, 1, 1, 9, 1, 0, 0);        // filler writes r9
    @(negedge clk); tick();
    set_iss(1, 3, 5, 1, 1, 4, 1, 0, 0);        // sub r4,r3,r5
    @(negedge clk); tick();
    set_iss(0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    n_checks++; if (fwd_a_o !== 2'd2) $display("FAIL fwd2_sel: got %0d want 2", fwd_a_o); else n_pass++;
    tick();
    drain();
  endtask

  task automatic test_load_use();
    set_iss(1, 1, 0, 1, 0, 4, 1, 1, 0);        // lw r4,0(r1)
    @(negedge clk);
    n_checks++; if (stall_o !== 1'b0) $display("FAIL lu_lw_stall: got %b want 0", stall_o); else n_pass++;
    tick();
    set_iss(1, 6, 4, 1, 1, 5, 1, 0, 0);        // consumer reads r4 on source B
    @(negedge clk);
    n_checks++; if (stall_o !== 1'b1 || bubble_o !== 1'b1) $display("FAIL lu_first: got stall=%b bubble=%b want 1/1", stall_o, bubble_o); else n_pass++;
    tick();
    @(negedge clk);
    n_checks++; if (stall_o !== 1'b0 || bubble_o !== 1'b0) $display("FAIL lu_second: got stall=%b bubble=%b want 0/0", stall_o, bubble_o); else n_pass++;
    tick();
    set_iss(0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    n_checks++; if (fwd_b_o !== 2'd2 || fwd_a_o !== 2'd0) $display("FAIL lu_fwd: got a=%0d b=%0d want 0/2", fwd_a_o, fwd_b_o); else n_pass++;
    tick();
    drain();
  endtask

  task automatic test_zero_reg();
    set_iss(1, 1, 2, 1, 1, 0, 1, 0, 0);        // add r0,r1,r2
    @(negedge clk); tick();
    set_iss(1, 0, 0, 1, 1, 7, 1, 0, 0);        // or r7,r0,r0
    @(negedge clk);
    n_checks++; if (stall_o !== 1'b0) $display("FAIL zero_stall: got %b want 0", stall_o); else n_pass++;
    tick();
    set_iss(0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    n_checks++; if (fwd_a_o !== '0 || fwd_b_o !== '0) $display("FAIL zero_fwd: got %0d/%0d want 0/0", fwd_a_o, fwd_b_o); else n_pass++;
    tick();
    drain();
  endtask

  task automatic test_flush_lu();
    set_iss(1, 1, 0, 1, 0, 4, 1, 1, 0);        // lw r4
    @(negedge clk); tick();
    set_iss(1, 4, 2, 1, 1, 5, 1, 0, 0);
    flush_i = 1;
    @(negedge clk);
    n_checks++; if (bubble_o !== 1'b1 || stall_o !== 1'b0) $display("FAIL flush_lu: got bubble=%b stall=%b want 1/0", bubble_o, stall_o); else n_pass++;
    tick();
    flush_i = 0;
    drain();
  endtask

  task automatic test_multicycle();
    int holds;
    holds = 0;
    set_iss(1, 1, 2, 1, 1, 0, 0, 0, 3);        // mult, 3 extra EX cycles
    @(negedge clk);
    n_checks++; if (ex_hold_o !== 1'b0 || mc_cnt_o !== '0) $display("FAIL mc_issue: got hold=%b cnt=%0d want 0/0", ex_hold_o, mc_cnt_o); else n_pass++;
    tick();
    set_iss(1, 1, 2, 1, 1, 8, 1, 0, 0);        // add r8 waiting in ISS
    for (int i = 0; i < 4; i++) begin
      if (i == 1) flush_i = 1;
      @(negedge clk);
      n_checks++; if (mc_cnt_o !== CW'(3 - i)) $display("FAIL mc_cnt_%0d: got %0d want %0d", i, mc_cnt_o, 3 - i); else n_pass++;
      n_checks++; if (ex_hold_o !== (i < 3) || stall_o !== (i < 3)) $display("FAIL mc_hold_%0d: got hold=%b stall=%b want %0d", i, ex_hold_o, stall_o, i < 3); else n_pass++;
      if (i == 1) begin
        n_checks++; if (bubble_o !== 1'b0) $display("FAIL mc_flush_ignored: got bubble=%b want 0", bubble_o); else n_pass++;
      end
      if (ex_hold_o === 1'b1) holds++;
      tick();
      flush_i = 0;
    end
    n_checks++; if (holds != 3) $display("FAIL mc_hold_cycles: got %0d want 3", holds); else n_pass++;
    drain();
  endtask

  task automatic test_reset_mid_mc();
    set_iss(1, 1, 2, 1, 1, 1, 1, 0, 3);        // multicycle op writing r1
    @(negedge clk); tick();
    set_iss(1, 1, 2, 1, 1, 3, 1, 0, 0);        // add r3,r1,r2
    @(negedge clk); tick();
    @(negedge clk);
    n_checks++; if (mc_cnt_o !== CW'(2)) $display("FAIL rmc_pre: got cnt=%0d want 2", mc_cnt_o); else n_pass++;
    reset = 1;
    m_reset();
    #1;
    n_checks++; if (stall_o !== 1'b0 || bubble_o !== 1'b0 || ex_hold_o !== 1'b0) $display("FAIL rmc_ctl: got %b%b%b want 000", stall_o, bubble_o, ex_hold_o); else n_pass++;
    n_checks++; if (mc_cnt_o !== '0 || fwd_a_o !== '0 || fwd_b_o !== '0) $display("FAIL rmc_data: got cnt=%0d fwd=%0d/%0d want 0", mc_cnt_o, fwd_a_o, fwd_b_o); else n_pass++;
    @(posedge clk);
    #1;
    reset = 0;
    @(negedge clk);
    n_checks++; if (stall_o !== 1'b0) $display("FAIL rmc_post_stall: got %b want 0", stall_o); else n_pass++;
    tick();
    set_iss(0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    n_checks++; if (fwd_a_o !== '0 || fwd_b_o !== '0) $display("FAIL rmc_post_fwd: got %0d/%0d want 0/0", fwd_a_o, fwd_b_o); else n_pass++;
    tick();
    drain();
  endtask

  task automatic test_random();
    bit st_prev, e_stall, e_bubble, e_hold;
    int e_fa, e_fb, ka, kb;
    bit vld, ld, wr;
    st_prev = 0;
    for (int i = 0; i < 400; i++) begin
      if (!st_prev) begin
        vld = $urandom_range(0, 9) != 0;
        wr  = $urandom_range(0, 3) != 0;
        ld  = wr && ($urandom_range(0, 3) == 0);
        set_iss(vld, $urandom_range(0, 7), $urandom_range(0, 7), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), $urandom_range(0, 7), wr, ld,
                ($urandom_range(0, 7) == 0) ? $urandom_range(1, 3) : 0);
      end
      flush_i = ($urandom_range(0, 9) == 0);
      @(negedge clk);
      e_stall = m_stall(); e_bubble = m_bubble(); e_hold = m_hold();
      e_fa = m_fwd(pipe[0].rs, pipe[0].urs);
      e_fb = m_fwd(pipe[0].rt, pipe[0].urt);
      n_checks++; if (stall_o !== e_stall) $display("FAIL rnd_stall @%0d: got %b want %b", i, stall_o, e_stall); else n_pass++;
      n_checks++; if (bubble_o !== e_bubble) $display("FAIL rnd_bubble @%0d: got %b want %b", i, bubble_o, e_bubble); else n_pass++;
      n_checks++; if (ex_hold_o !== e_hold) $display("FAIL rnd_hold @%0d: got %b want %b", i, ex_hold_o, e_hold); else n_pass++;
      n_checks++; if (fwd_a_o !== FW'(e_fa)) $display("FAIL rnd_fwd_a @%0d: got %0d want %0d", i, fwd_a_o, e_fa); else n_pass++;
      n_checks++; if (fwd_b_o !== FW'(e_fb)) $display("FAIL rnd_fwd_b @%0d: got %0d want %0d", i, fwd_b_o, e_fb); else n_pass++;
      n_checks++; if (mc_cnt_o !== CW'(mcnt)) $display("FAIL rnd_cnt @%0d: got %0d want %0d", i, mc_cnt_o, mcnt); else n_pass++;
      ka = int'(fwd_a_o); kb = int'(fwd_b_o);
      n_checks++;
      if ((ka != 0 && ka <= DEPTH && ka < LOAD_STAGE && pipe[ka].ld) ||
          (kb != 0 && kb <= DEPTH && kb < LOAD_STAGE && pipe[kb].ld))
        $display("FAIL rnd_early_load_fwd @%0d: got fwd=%0d/%0d selecting a load below stage %0d", i, ka, kb, LOAD_STAGE);
      else n_pass++;
      st_prev = e_stall;
      tick();
    end
    flush_i = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_forward();
    test_load_use();
    test_zero_reg();
    test_flush_lu();
    test_multicycle();
    test_reset_mid_mc();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
